// File: rtl/switch_allocator_4port_pkg.sv
// Shared codes for the 4-port wormhole switch allocator:
// crossbar selects, route codes and per-output lock states.
package switch_allocator_4port_pkg;

    localparam int NPORT = 4;

    localparam logic [2:0] SW_NONE  = 3'b000;
    localparam logic [2:0] SW_X1    = 3'b001;
    localparam logic [2:0] SW_X2    = 3'b010;
    localparam logic [2:0] SW_Y1    = 3'b011;
    localparam logic [2:0] SW_LOCAL = 3'b100;

    localparam logic [1:0] RT_X1    = 2'd0;
    localparam logic [1:0] RT_X2    = 2'd1;
    localparam logic [1:0] RT_Y     = 2'd2;
    localparam logic [1:0] RT_LOCAL = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Select code of input idx is idx+1 (X1=001 .. LOCAL=100).
    function automatic logic [2:0] sw_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/switch_allocator_4port_port.sv
// One output of the switch allocator: round-robin grant,
// lock to the winner until its tail flit transfers.
module sw_alloc_port
    import switch_allocator_4port_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] valid_i,
    input  logic [3:0] tail_i,
    input  logic       full_i,
    output logic [2:0] sw_o,
    output logic       locked_o,
    output logic [1:0] owner_o
);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] sw_q, sw_d;
    logic       found;
    logic       xfer;
    logic [1:0] cand;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            sw_q    <= SW_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        sw_d    = sw_q;
        found   = 1'b0;
        xfer    = 1'b0;
        cand    = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                sw_d = SW_NONE;
                for (int k = 0; k < NPORT; k++) begin
                    cand = ptr_q + 2'(k);
                    if (!found && req_i[cand]) begin
                        found   = 1'b1;
                        state_d = ST_LOCKED;
                        owner_d = cand;
                        ptr_d   = cand + 2'd1;
                        sw_d    = sw_code(cand);
                    end
                end
            end
            ST_LOCKED: begin
                // Same advance condition the flow-control stage uses.
                xfer = valid_i[owner_q] && !full_i;
                sw_d = sw_code(owner_q);
                if (xfer && tail_i[owner_q]) begin
                    state_d = ST_IDLE;
                    sw_d    = SW_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sw_d    = SW_NONE;
            end
        endcase
    end

    assign sw_o     = sw_q;
    assign locked_o = (state_q == ST_LOCKED);
    assign owner_o  = owner_q;

endmodule

// File: rtl/switch_allocator_4port.sv
// Wormhole switch allocator for the X1/X2/Y/LOCAL router:
// four independent output arbiters sharing an input-busy mask.
module switch_allocator_4port
    import switch_allocator_4port_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_x1,
    input  logic       valid_x2,
    input  logic       valid_y,
    input  logic       valid_local,
    input  logic [1:0] route_x1,
    input  logic [1:0] route_x2,
    input  logic [1:0] route_y,
    input  logic [1:0] route_local,
    input  logic       tail_x1,
    input  logic       tail_x2,
    input  logic       tail_y,
    input  logic       tail_local,
    input  logic       full_x1,
    input  logic       full_x2,
    input  logic       full_y,
    input  logic       full_local,
    output logic [2:0] out_x1_sw,
    output logic [2:0] out_x2_sw,
    output logic [2:0] out_y_sw,
    output logic [2:0] out_local_sw
);

    logic [3:0] valid;
    logic [3:0] tail;
    logic [3:0] full;
    logic [1:0] route [NPORT];
    logic [3:0] busy;
    logic [3:0] req   [NPORT];
    logic [3:0] lock;
    logic [1:0] owner [NPORT];
    logic [2:0] sw    [NPORT];

    assign valid = {valid_local, valid_y, valid_x2, valid_x1};
    assign tail  = {tail_local, tail_y, tail_x2, tail_x1};
    assign full  = {full_local, full_y, full_x2, full_x1};
    assign route[0] = route_x1;
    assign route[1] = route_x2;
    assign route[2] = route_y;
    assign route[3] = route_local;

    // An input mid-packet on one output may not be granted by another.
    always_comb begin
        busy = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (lock[o] && owner[o] == 2'(i)) busy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = valid[i] && (route[i] == 2'(o)) && !busy[i];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_port
        sw_alloc_port u_port (
            .clk_i    (clk),
            .rst_i    (rst),
            .req_i    (req[o]),
            .valid_i  (valid),
            .tail_i   (tail),
            .full_i   (full[o]),
            .sw_o     (sw[o]),
            .locked_o (lock[o]),
            .owner_o  (owner[o])
        );
    end

    assign out_x1_sw    = sw[0];
    assign out_x2_sw    = sw[1];
    assign out_y_sw     = sw[2];
    assign out_local_sw = sw[3];

endmodule

// File: tb/tb_switch_allocator_4port.sv
// Directed bench for switch_allocator_4port: reset, single-flit,
// round robin, backpressure lock, busy input and mid-packet reset.
module tb_switch_allocator_4port;

    logic       clk;
    logic       rst;
    logic [3:0] v;
    logic [3:0] tl;
    logic [3:0] fl;
    logic [1:0] rt [4];
    logic [2:0] o_x1, o_x2, o_y, o_lc;

    int errors;
    int checks;

    switch_allocator_4port dut (
        .clk          (clk),
        .rst          (rst),
        .valid_x1     (v[0]),
        .valid_x2     (v[1]),
        .valid_y      (v[2]),
        .valid_local  (v[3]),
        .route_x1     (rt[0]),
        .route_x2     (rt[1]),
        .route_y      (rt[2]),
        .route_local  (rt[3]),
        .tail_x1      (tl[0]),
        .tail_x2      (tl[1]),
        .tail_y       (tl[2]),
        .tail_local   (tl[3]),
        .full_x1      (fl[0]),
        .full_x2      (fl[1]),
        .full_y       (fl[2]),
        .full_local   (fl[3]),
        .out_x1_sw    (o_x1),
        .out_x2_sw    (o_x2),
        .out_y_sw     (o_y),
        .out_local_sw (o_lc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        v  = '0;
        tl = '0;
        fl = '0;
        for (int i = 0; i < 4; i++) rt[i] = 2'd0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        v   = 4'hf;
        tl  = 4'b0101;
        rt[0] = 2'd3; rt[1] = 2'd2; rt[2] = 2'd1; rt[3] = 2'd0;
        tick();
        tick();
        checks++;
        if ({o_x1, o_x2, o_y, o_lc} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outs got=%h want=000", {o_x1, o_x2, o_y, o_lc});
        end
        rst = 1'b0;
        clear_in();
        v[0] = 1'b1; rt[0] = 2'd3; tl[0] = 1'b1;
        tick();
        checks++;
        if (o_lc !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant got=%b want=001", o_lc);
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        v[0] = 1'b1; rt[0] = 2'd3; tl[0] = 1'b1;
        tick();
        checks++;
        if ({o_x1, o_x2, o_y, o_lc} !== {9'b0, 3'b001}) begin
            errors++;
            $display("FAIL single_grant got=%b want=000000000001",
                     {o_x1, o_x2, o_y, o_lc});
        end
        tick();
        v[0] = 1'b0;
        checks++;
        if ({o_x1, o_x2, o_y, o_lc} !== 12'b0) begin
            errors++;
            $display("FAIL single_release got=%b want=0", {o_x1, o_x2, o_y, o_lc});
        end
        tick();
        checks++;
        if (o_lc !== 3'b000) begin
            errors++;
            $display("FAIL single_idle got=%b want=000", o_lc);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp [9];
        exp[0] = 3'b001; exp[1] = 3'b000; exp[2] = 3'b010;
        exp[3] = 3'b000; exp[4] = 3'b011; exp[5] = 3'b000;
        exp[6] = 3'b100; exp[7] = 3'b000; exp[8] = 3'b001;
        do_reset();
        v  = 4'hf;
        tl = 4'hf;
        for (int i = 0; i < 4; i++) rt[i] = 2'd2;
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++;
            if (o_y !== exp[c]) begin
                errors++;
                $display("FAIL rr_cycle%0d got=%b want=%b", c, o_y, exp[c]);
            end
        end
        clear_in();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        v[2] = 1'b1; rt[2] = 2'd1;
        v[3] = 1'b1; rt[3] = 2'd1;
        tick();
        checks++;
        if (o_x2 !== 3'b011) begin
            errors++;
            $display("FAIL bp_grant got=%b want=011", o_x2);
        end
        tick();
        fl[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (o_x2 !== 3'b011) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b want=011", c, o_x2);
            end
        end
        fl[1] = 1'b0;
        tick();
        checks++;
        if (o_x2 !== 3'b011) begin
            errors++;
            $display("FAIL bp_flit2 got=%b want=011", o_x2);
        end
        tl[2] = 1'b1;
        tick();
        v[2] = 1'b0; tl[2] = 1'b0;
        checks++;
        if (o_x2 !== 3'b000) begin
            errors++;
            $display("FAIL bp_release got=%b want=000", o_x2);
        end
        tick();
        checks++;
        if (o_x2 !== 3'b100) begin
            errors++;
            $display("FAIL bp_next_owner got=%b want=100", o_x2);
        end
        clear_in();
        tick();
    endtask

    task automatic test_busy_input();
        do_reset();
        v[1] = 1'b1; rt[1] = 2'd2;
        tick();
        checks++;
        if (o_y !== 3'b010) begin
            errors++;
            $display("FAIL busy_grant_y got=%b want=010", o_y);
        end
        fl[2] = 1'b1; tl[1] = 1'b1; rt[1] = 2'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({o_x1, o_y} !== {3'b000, 3'b010}) begin
                errors++;
                $display("FAIL busy_hold%0d got x1=%b y=%b want x1=000 y=010",
                         c, o_x1, o_y);
            end
        end
        fl[2] = 1'b0;
        tick();
        tl[1] = 1'b0;
        checks++;
        if ({o_x1, o_y} !== 6'b0) begin
            errors++;
            $display("FAIL busy_release got x1=%b y=%b want 000 000", o_x1, o_y);
        end
        tick();
        checks++;
        if (o_x1 !== 3'b010) begin
            errors++;
            $display("FAIL busy_regrant got=%b want=010", o_x1);
        end
        clear_in();
        tick();
    endtask

    task automatic test_parallel();
        do_reset();
        v[0] = 1'b1; rt[0] = 2'd2; tl[0] = 1'b1;
        v[2] = 1'b1; rt[2] = 2'd0; tl[2] = 1'b1;
        v[3] = 1'b1; rt[3] = 2'd3; tl[3] = 1'b1;
        tick();
        clear_in();
        checks++;
        if ({o_x1, o_x2, o_y, o_lc} !== {3'b011, 3'b000, 3'b001, 3'b100}) begin
            errors++;
            $display("FAIL parallel got=%b want=011000001100",
                     {o_x1, o_x2, o_y, o_lc});
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        v[3] = 1'b1; rt[3] = 2'd0;
        tick();
        tick();
        checks++;
        if (o_x1 !== 3'b100) begin
            errors++;
            $display("FAIL mid_locked got=%b want=100", o_x1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (o_x1 !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got=%b want=000", o_x1);
        end
        v[0] = 1'b1; rt[0] = 2'd0; tl[0] = 1'b1;
        tl[3] = 1'b1;
        tick();
        checks++;
        if (o_x1 !== 3'b001) begin
            errors++;
            $display("FAIL mid_fresh_x1 got=%b want=001", o_x1);
        end
        v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        checks++;
        if (o_x1 !== 3'b000) begin
            errors++;
            $display("FAIL mid_bubble got=%b want=000", o_x1);
        end
        tick();
        checks++;
        if (o_x1 !== 3'b100) begin
            errors++;
            $display("FAIL mid_local_next got=%b want=100", o_x1);
        end
        clear_in();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_in();
        rst = 1'b1;
        #2;
        test_reset();
        test_single_flit();
        test_round_robin();
        test_backpressure();
        test_busy_input();
        test_parallel();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
